// File: rtl/regfile_clr.sv
// ---------------------------------------------------------------------------
// regfile_clr
//
// WIDTH x DEPTH register file sitting between the datapath bus and the ALU
// operand inputs. Two combinational read ports (A, B), one synchronous write
// port (R), an optional hardwired-zero register 0, optional write-through
// bypass on the read ports, and a bulk-clear engine that zeroes the file one
// entry per cycle under a request/busy/done handshake.
//
// Parameters:
//   WIDTH   - data width of each register and of bus/a/b
//   DEPTH   - number of registers (power of two, >= 2)
//   ZERO_R0 - 1: register 0 always reads 0 and ignores writes
//   BYPASS  - 1: a read port returns bus when the same-cycle write (IDLE only)
//             targets the selected register
//   SELW    - selector width, $clog2(DEPTH) (derived, not overridable)
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - asynchronous active-low reset
//   wen     - write enable for port R
//   selA    - read port A register select
//   selB    - read port B register select
//   selR    - write port register select
//   bus     - write data
//   clrReq  - bulk-clear request, sampled on the rising edge in IDLE
//   a       - read port A data (combinational)
//   b       - read port B data (combinational)
//   clrBusy - clear engine active (registered)
//   clrDone - one-cycle pulse after the last entry is cleared (registered)
// ---------------------------------------------------------------------------
module regfile_clr #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 16,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned SELW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [SELW-1:0]  selA,
    input  logic [SELW-1:0]  selB,
    input  logic [SELW-1:0]  selR,
    input  logic [WIDTH-1:0] bus,
    input  logic             clrReq,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             clrBusy,
    output logic             clrDone
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [SELW-1:0] LAST = SELW'(DEPTH - 1);

    state_t           state;
    logic [SELW-1:0]  clrIdx;
    logic [WIDTH-1:0] mem [DEPTH];

    // A write is only accepted in IDLE; a write to r0 is dropped when r0 is
    // hardwired to zero. The same qualifier gates the read bypass so that a
    // bypassed value is always exactly what will be stored.
    logic wr_ok;
    logic byp_en;

    always_comb begin
        wr_ok  = (state == IDLE) && wen && !(ZERO_R0 && (selR == '0));
        byp_en = BYPASS && wr_ok;
    end

    // Storage, clear engine and handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state   <= IDLE;
            clrIdx  <= '0;
            clrBusy <= 1'b0;
            clrDone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clrDone <= 1'b0;
                    // A write coinciding with the clear request still lands;
                    // the sweep that follows zeroes it anyway.
                    if (wr_ok) begin
                        mem[selR] <= bus;
                    end
                    if (clrReq) begin
                        state   <= CLEAR;
                        clrIdx  <= '0;
                        clrBusy <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clrIdx] <= '0;
                    clrIdx      <= clrIdx + 1'b1;
                    clrDone     <= 1'b0;
                    if (clrIdx == LAST) begin
                        state   <= IDLE;
                        clrBusy <= 1'b0;
                        clrDone <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clrIdx  <= '0;
                    clrBusy <= 1'b0;
                    clrDone <= 1'b0;
                end
            endcase
        end
    end

    // Read port A
    always_comb begin
        a = mem[selA];
        if (ZERO_R0 && (selA == '0)) begin
            a = '0;
        end else if (byp_en && (selR == selA)) begin
            a = bus;
        end
    end

    // Read port B
    always_comb begin
        b = mem[selB];
        if (ZERO_R0 && (selB == '0)) begin
            b = '0;
        end else if (byp_en && (selR == selB)) begin
            b = bus;
        end
    end

endmodule

// File: tb/tb_regfile_clr.sv
// ---------------------------------------------------------------------------
// tb_regfile_clr
//
// Drives three regfile_clr instances with shared stimulus, one per
// configuration:
//   u0: ZERO_R0=0, BYPASS=1   u1: ZERO_R0=1, BYPASS=0   u2: ZERO_R0=1, BYPASS=1
// Each instance is compared against a behavioural model of the register file
// (plain arrays plus a clear-progress count), followed by directed checks
// against fixed constants from the test plan and a randomized phase.
// ---------------------------------------------------------------------------
module tb_regfile_clr;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [3:0]  selA, selB, selR;
    logic [15:0] bus;
    logic        clrReq;

    logic [15:0] a_o    [NI];
    logic [15:0] b_o    [NI];
    logic        busy_o [NI];
    logic        done_o [NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_clr #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1'b0), .BYPASS(1'b1)) u0 (
        .clk(clk), .rst(rst), .wen(wen), .selA(selA), .selB(selB), .selR(selR),
        .bus(bus), .clrReq(clrReq), .a(a_o[0]), .b(b_o[0]),
        .clrBusy(busy_o[0]), .clrDone(done_o[0]));

    regfile_clr #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1'b1), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst(rst), .wen(wen), .selA(selA), .selB(selB), .selR(selR),
        .bus(bus), .clrReq(clrReq), .a(a_o[1]), .b(b_o[1]),
        .clrBusy(busy_o[1]), .clrDone(done_o[1]));

    regfile_clr #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1'b1), .BYPASS(1'b1)) u2 (
        .clk(clk), .rst(rst), .wen(wen), .selA(selA), .selB(selB), .selR(selR),
        .bus(bus), .clrReq(clrReq), .a(a_o[2]), .b(b_o[2]),
        .clrBusy(busy_o[2]), .clrDone(done_o[2]));

    // ---------------- reference model ----------------
    logic [15:0] m_mem [NI][16];
    bit          m_clearing;
    int          m_cleared;     // entries already zeroed in the current sweep
    bit          m_done;

    function automatic bit cfg_zr(input int c);
        return (c != 0);
    endfunction

    function automatic bit cfg_bp(input int c);
        return (c != 1);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NI; c++)
            for (int i = 0; i < 16; i++)
                m_mem[c][i] = 16'h0000;
        m_clearing = 1'b0;
        m_cleared  = 0;
        m_done     = 1'b0;
    endtask

    // Effect of one rising edge, using the inputs held before it.
    task automatic model_edge();
        if (!m_clearing) begin
            for (int c = 0; c < NI; c++)
                if (wen && !(cfg_zr(c) && selR == 4'd0))
                    m_mem[c][selR] = bus;
            if (clrReq) begin
                m_clearing = 1'b1;
                m_cleared  = 0;
            end
            m_done = 1'b0;
        end else begin
            for (int c = 0; c < NI; c++)
                m_mem[c][m_cleared] = 16'h0000;
            m_cleared++;
            m_done = (m_cleared == 16);
            if (m_cleared == 16) m_clearing = 1'b0;
        end
    endtask

    function automatic logic [15:0] exp_rd(input int c, input logic [3:0] sel);
        if (cfg_zr(c) && sel == 4'd0) return 16'h0000;
        if (cfg_bp(c) && !m_clearing && wen && selR == sel) return bus;
        return m_mem[c][sel];
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NI; c++) begin
            chk($sformatf("a_u%0d", c), a_o[c], exp_rd(c, selA));
            chk($sformatf("b_u%0d", c), b_o[c], exp_rd(c, selB));
            chk($sformatf("busy_u%0d", c), {15'd0, busy_o[c]}, {15'd0, m_clearing});
            chk($sformatf("done_u%0d", c), {15'd0, done_o[c]}, {15'd0, m_done});
        end
    endtask

    // Apply inputs mid-cycle and check the combinational view.
    task automatic drive(input logic w, input logic [3:0] sr, input logic [15:0] d,
                         input logic cr, input logic [3:0] sa, input logic [3:0] sb);
        wen = w; selR = sr; bus = d; clrReq = cr; selA = sa; selB = sb;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [3:0] sr, input logic [15:0] d);
        drive(1'b1, sr, d, 1'b0, sr, 4'd0);
        tick();
    endtask

    int ndone;
    logic [15:0] v;

    initial begin
        // ---- reset / basic ----
        rst = 1'b0; wen = 1'b0; selA = '0; selB = '0; selR = '0; bus = '0; clrReq = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_busy", {15'd0, busy_o[0]}, 16'h0000);
        chk("rst_done", {15'd0, done_o[0]}, 16'h0000);
        tick(); tick();
        rst = 1'b1;

        wr(4'd3, 16'h1234);
        wr(4'd7, 16'hBEEF);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 4'd7);
        chk("basic_a_r3", a_o[0], 16'h1234);
        chk("basic_b_r7", b_o[0], 16'hBEEF);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'(i), 4'(15 - i));
            tick();
        end

        // ---- bypass ----
        drive(1'b1, 4'd5, 16'hA5A5, 1'b0, 4'd5, 4'd3);
        chk("byp_u0_same", a_o[0], 16'hA5A5);
        chk("byp_u1_old",  a_o[1], 16'h0000);
        chk("byp_u2_same", a_o[2], 16'hA5A5);
        tick();
        chk("byp_u1_next", a_o[1], 16'hA5A5);

        // ---- zero register ----
        wr(4'd0, 16'hFFFF);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);
        chk("zr_u0", a_o[0], 16'hFFFF);
        chk("zr_u1", a_o[1], 16'h0000);
        chk("zr_u2", a_o[2], 16'h0000);

        // ---- clear ----
        for (int i = 0; i < 16; i++) wr(4'(i), 16'h0100 + 16'(i));
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 4'd15);
        tick();                                   // edge k
        chk("clr_busy_k", {15'd0, busy_o[0]}, 16'h0001);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd4, 4'd15);
        ndone = 0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            v = (j >= 5) ? 16'h0000 : 16'h0104;
            chk("clr_r4", a_o[0], v);
            chk("clr_busy", {15'd0, busy_o[0]}, (j < 16) ? 16'h0001 : 16'h0000);
            if (done_o[0]) ndone++;
        end
        chk("clr_done_last", {15'd0, done_o[0]}, 16'h0001);
        tick();
        chk("clr_done_clr", {15'd0, done_o[0]}, 16'h0000);
        chk("clr_done_cnt", 16'(ndone), 16'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'(i), 4'(i));
            chk("clr_all_zero", a_o[0], 16'h0000);
        end

        // ---- clear contention + back-to-back ----
        wr(4'd15, 16'h5555);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 4'd15);
        tick();                                   // edge k
        drive(1'b1, 4'd15, 16'h7777, 1'b1, 4'd15, 4'd15);
        chk("cont_nobyp", a_o[0], 16'h5555);
        ndone = 0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            if (done_o[0]) ndone++;
        end
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd15, 4'd15);
        for (int j = 4; j <= 16; j++) begin
            tick();
            if (done_o[0]) ndone++;
        end
        chk("cont_done_cnt", 16'(ndone), 16'd1);
        chk("cont_r15", a_o[0], 16'h0000);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 4'd15);   // request in done cycle
        tick();
        chk("b2b_busy", {15'd0, busy_o[0]}, 16'h0001);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd1, 4'd2);
        for (int j = 1; j <= 16; j++) tick();
        chk("b2b_done", {15'd0, done_o[0]}, 16'h0001);
        tick();

        // ---- reset mid-clear ----
        for (int i = 0; i < 16; i++) wr(4'(i), 16'hC000 + 16'(i));
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd12, 4'd13);
        tick();
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd12, 4'd13);
        for (int j = 1; j <= 6; j++) tick();
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rmc_busy", {15'd0, busy_o[0]}, 16'h0000);
        chk("rmc_a", a_o[0], 16'h0000);
        ndone = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (done_o[0]) ndone++;
        end
        rst = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (done_o[0]) ndone++;
        end
        chk("rmc_no_done", 16'(ndone), 16'd0);
        wr(4'd9, 16'h4242);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd9, 4'd12);
        chk("rmc_write", a_o[0], 16'h4242);
        chk("rmc_zero", b_o[0], 16'h0000);

        // ---- randomized ----
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                check_all();
                tick();
                rst = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  ($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
